// File: rtl/pid_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pid_uart_ctrl
// Description : Framed UART command sequencer for the PID configuration
//               registers (KP, KI, KD, SETPOINT). Optional inter-byte timeout
//               is enabled by defining PID_UART_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_uart_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] KP_INIT        = 16'd0,
    parameter logic [15:0] KI_INIT        = 16'd0,
    parameter logic [15:0] KD_INIT        = 16'd0,
    parameter logic [15:0] SP_INIT        = 16'd0,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_byte,
    input  logic        tx_busy,
    output logic        tx_send,
    output logic [7:0]  tx_byte,
    output logic [15:0] kp,
    output logic [15:0] ki,
    output logic [15:0] kd,
    output logic [15:0] setpoint,
    output logic        cfg_update,
    output logic        overrun,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CMD        = 4'd1,
        S_DHI        = 4'd2,
        S_DLO        = 4'd3,
        S_CHK        = 4'd4,
        S_EXEC       = 4'd5,
        S_TX_LOAD    = 4'd6,
        S_TX_WAIT_HI = 4'd7,
        S_TX_WAIT_LO = 4'd8
    } state_t;

    localparam logic [7:0] C_ACK = 8'h06;
    localparam logic [7:0] C_NAK = 8'h15;

    state_t      state_q;
    logic        rx_rdy_q;
    logic [7:0]  cmd_q;
    logic [7:0]  dhi_q;
    logic [7:0]  dlo_q;
    logic [7:0]  chk_q;
    logic [7:0]  resp_q [0:3];
    logic [2:0]  resp_len_q;
    logic [2:0]  resp_idx_q;
    logic        tx_send_q;
    logic [7:0]  tx_byte_q;
    logic [15:0] kp_q;
    logic [15:0] ki_q;
    logic [15:0] kd_q;
    logic [15:0] sp_q;
    logic        cfg_update_q;
    logic        overrun_q;
    logic        frame_err_q;

    logic        byte_ev_w;
    logic        chk_ok_w;
    logic        in_frame_w;
    logic        busy_state_w;
    logic        to_hit_w;
    logic [15:0] sel_val_w;

    assign byte_ev_w    = rx_rdy & ~rx_rdy_q;
    assign in_frame_w   = (state_q == S_CMD) || (state_q == S_DHI) ||
                          (state_q == S_DLO) || (state_q == S_CHK);
    assign busy_state_w = (state_q == S_EXEC) || (state_q == S_TX_LOAD) ||
                          (state_q == S_TX_WAIT_HI) || (state_q == S_TX_WAIT_LO);
    assign chk_ok_w     = cmd_q[7] ? (chk_q == cmd_q)
                                   : (chk_q == (cmd_q ^ dhi_q ^ dlo_q));

    always_comb begin
        sel_val_w = kp_q;
        case (cmd_q[1:0])
            2'd0:    sel_val_w = kp_q;
            2'd1:    sel_val_w = ki_q;
            2'd2:    sel_val_w = kd_q;
            default: sel_val_w = sp_q;
        endcase
    end

`ifdef PID_UART_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt_q;

    assign to_hit_w = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside a frame, so entering CMD always starts a fresh count.
    always_ff @(posedge clk_in) begin
        if (reset || byte_ev_w || !in_frame_w) begin
            to_cnt_q <= '0;
        end else if (!to_hit_w) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    // Without the timeout a partial frame waits indefinitely.
    assign to_hit_w = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rx_rdy_q     <= 1'b0;
            cmd_q        <= 8'd0;
            dhi_q        <= 8'd0;
            dlo_q        <= 8'd0;
            chk_q        <= 8'd0;
            for (int i = 0; i < 4; i++) resp_q[i] <= 8'd0;
            resp_len_q   <= 3'd0;
            resp_idx_q   <= 3'd0;
            tx_send_q    <= 1'b0;
            tx_byte_q    <= 8'd0;
            kp_q         <= KP_INIT;
            ki_q         <= KI_INIT;
            kd_q         <= KD_INIT;
            sp_q         <= SP_INIT;
            cfg_update_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_rdy_q     <= rx_rdy;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (byte_ev_w && busy_state_w) overrun_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (byte_ev_w && rx_byte == SYNC_BYTE) state_q <= S_CMD;
                end
                S_CMD: begin
                    if (byte_ev_w) begin
                        cmd_q   <= rx_byte;
                        state_q <= rx_byte[7] ? S_CHK : S_DHI;
                    end else if (to_hit_w) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DHI: begin
                    if (byte_ev_w) begin
                        dhi_q   <= rx_byte;
                        state_q <= S_DLO;
                    end else if (to_hit_w) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DLO: begin
                    if (byte_ev_w) begin
                        dlo_q   <= rx_byte;
                        state_q <= S_CHK;
                    end else if (to_hit_w) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHK: begin
                    if (byte_ev_w) begin
                        chk_q   <= rx_byte;
                        state_q <= S_EXEC;
                    end else if (to_hit_w) begin
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    resp_idx_q <= 3'd0;
                    state_q    <= S_TX_LOAD;
                    if (!chk_ok_w) begin
                        frame_err_q <= 1'b1;
                        resp_q[0]   <= C_NAK;
                        resp_len_q  <= 3'd1;
                    end else if (cmd_q[7]) begin
                        resp_q[0]   <= SYNC_BYTE;
                        resp_q[1]   <= sel_val_w[15:8];
                        resp_q[2]   <= sel_val_w[7:0];
                        resp_q[3]   <= sel_val_w[15:8] ^ sel_val_w[7:0];
                        resp_len_q  <= 3'd4;
                    end else begin
                        case (cmd_q[1:0])
                            2'd0:    kp_q <= {dhi_q, dlo_q};
                            2'd1:    ki_q <= {dhi_q, dlo_q};
                            2'd2:    kd_q <= {dhi_q, dlo_q};
                            default: sp_q <= {dhi_q, dlo_q};
                        endcase
                        cfg_update_q <= 1'b1;
                        resp_q[0]    <= C_ACK;
                        resp_len_q   <= 3'd1;
                    end
                end
                S_TX_LOAD: begin
                    tx_byte_q <= resp_q[resp_idx_q[1:0]];
                    tx_send_q <= 1'b1;
                    state_q   <= S_TX_WAIT_HI;
                end
                S_TX_WAIT_HI: begin
                    // The UART only samples send on its baud tick, so hold it until busy.
                    if (tx_busy) begin
                        tx_send_q <= 1'b0;
                        state_q   <= S_TX_WAIT_LO;
                    end
                end
                S_TX_WAIT_LO: begin
                    if (!tx_busy) begin
                        resp_idx_q <= resp_idx_q + 3'd1;
                        state_q    <= (resp_idx_q + 3'd1 == resp_len_q) ? S_IDLE : S_TX_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_send    = tx_send_q;
    assign tx_byte    = tx_byte_q;
    assign kp         = kp_q;
    assign ki         = ki_q;
    assign kd         = kd_q;
    assign setpoint   = sp_q;
    assign cfg_update = cfg_update_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: doc/pid_uart_ctrl.md
Name: pid_uart_ctrl

Overview:
- Command sequencer between the UART block (receiver + transmitter) and the PID core.
- Parses framed byte commands from the UART receive side and writes or reads four 16-bit PID configuration registers (KP, KI, KD, SETPOINT).
- Drives the UART transmit side, one byte at a time, to return ACK, NAK or read-data frames.
- Sole owner of the UART send/send_data inputs.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- KP_INIT, 16'd0, reset value of KP register.
- KI_INIT, 16'd0, reset value of KI register.
- KD_INIT, 16'd0, reset value of KD register.
- SP_INIT, 16'd0, reset value of SETPOINT register.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk_in cycles; used only with the optional feature.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_rdy  input  1  UART data_rdy; level, byte valid while high.
- rx_byte  input  8  UART received data.
- tx_busy  input  1  UART busy_o.
- tx_send  output  1  to UART send.
- tx_byte  output  8  to UART send_data.
- kp  output  16  KP register.
- ki  output  16  KI register.
- kd  output  16  KD register.
- setpoint  output  16  SETPOINT register.
- cfg_update  output  1  one-cycle pulse when any register is written.
- overrun  output  1  sticky: byte arrived while a response was transmitting.
- frame_err  output  1  one-cycle pulse on checksum failure.

Behaviour:
- Reset values: tx_send=0, tx_byte=0, kp/ki/kd/setpoint = *_INIT, cfg_update=0, overrun=0, frame_err=0, FSM=IDLE. A reset mid-frame or mid-transmit aborts immediately; registers return to their INIT values.
- Byte event: rising edge of rx_rdy (registered previous value). Exactly one event per byte, regardless of how long rx_rdy stays high.
- Frame format: SYNC, CMD, [DHI, DLO], CHK.
  - CMD[7]: 1 = read, 0 = write. CMD[1:0]: register index (0 KP, 1 KI, 2 KD, 3 SETPOINT). CMD[6:2] ignored.
  - Write frame: CHK = CMD^DHI^DLO. Read frame: CHK = CMD, with no data bytes.
- FSM states: IDLE, CMD, DHI, DLO, CHK, EXEC, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
  - IDLE: byte==SYNC_BYTE -> CMD; any other byte is discarded.
  - CMD: latch CMD; read -> CHK, write -> DHI.
  - DHI -> DLO -> CHK: latch each byte.
  - CHK: latch CHK -> EXEC.
- EXEC (one cycle):
  - Checksum bad: frame_err=1, response = {8'h15} (NAK).
  - Write OK: the register takes {DHI,DLO} on this cycle, cfg_update=1 on the same cycle, response = {8'h06} (ACK).
  - Read OK: response = {SYNC_BYTE, hi, lo, hi^lo}, 4 bytes, captured from the register value at EXEC.
  - All cases -> TX_LOAD with resp_idx=0.
- TX_LOAD: tx_byte=resp[resp_idx], tx_send=1 -> TX_WAIT_HI.
- TX_WAIT_HI: hold tx_send=1 and tx_byte stable until tx_busy=1, then tx_send=0 -> TX_WAIT_LO. tx_send must be held because the UART samples only on clk_en ticks.
- TX_WAIT_LO: on tx_busy=0, resp_idx+1. If bytes remain -> TX_LOAD, else -> IDLE.
- tx_busy already 1 on entering TX_LOAD: stays in TX_WAIT_HI until it is seen 1. Because it already is, the FSM proceeds and then waits for it to fall. No byte is lost: the transmitter accepts send only when idle.
- Byte events in EXEC/TX_*: the byte is dropped and overrun is set to 1 (sticky until reset).
- A SYNC_BYTE received mid-frame (CMD..CHK) is treated as data, not a resync; recovery relies on the checksum or the timeout.
- No back-to-back register writes: at least one response frame always separates them.

Optional Feature:
- Macro: PID_UART_TIMEOUT_EN.
- Defined: a counter clears on every byte event and on entering CMD.
  - In CMD/DHI/DLO/CHK, reaching TIMEOUT_CYCLES-1 without a byte event returns the FSM to IDLE silently: no response, no frame_err, registers unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Not defined: no counter; partial frames wait indefinitely.

Test Plan:
- Write KP: bytes A5,01... use CMD=00, DHI=12, DLO=34, CHK=26 -> kp=16'h1234 and cfg_update pulses once; the transmitter sees exactly one send, of byte 06.
- Read back: A5,80,80 -> tx bytes A5,12,34,26 in order; each send is held until busy rises; no byte issued while busy=1.
- Bad checksum: A5,03,00,10,00 -> setpoint unchanged, frame_err pulses once, tx byte 15.
- Garbage then frame: 00,FF,A5,02,AB,CD,64 -> kd=16'hABCD; the leading 00 and FF are ignored.
- Overrun: send byte 55 while the ACK is transmitting -> overrun=1 and stays 1; the next valid frame still executes.
- Reset mid-frame: A5,01,7F then reset -> ki=KI_INIT, FSM in IDLE. With PID_UART_TIMEOUT_EN and TIMEOUT_CYCLES=100: A5,01 then 100 idle cycles, then 00,05,04 -> no register change and no response.
